// File: rtl/obstacle_detector_array_if.sv
// Bundle of the per-channel sensor inputs and detector outputs.
// master: the pin-mapping side (drives enables and sensors).
// slave: the detector itself.
interface obstacle_detector_array_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   sensor;
  logic [NUM_CH-1:0]   obstacle;
  logic [2*NUM_CH-1:0] buzz_level;
  logic [NUM_CH-1:0]   buzz_out;
  logic                window_done;

  modport master (
    output ch_en, sensor,
    input  obstacle, buzz_level, buzz_out, window_done
  );

  modport slave (
    input  ch_en, sensor,
    output obstacle, buzz_level, buzz_out, window_done
  );
endinterface

// File: rtl/obstacle_detector_array.sv
// Multi-channel obstacle detector: per channel a 2-flop synchroniser, a
// debouncer, windowed occupancy measurement quantised to a 2-bit urgency
// level, and a buzzer whose beep rate follows that level.
module obstacle_detector_array #(
  parameter int NUM_CH    = 2,
  parameter int DEB_LEN   = 4,
  parameter int WIN_LEN   = 256,
  parameter int BEEP_BASE = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  obstacle_detector_array_if.slave  bus
);
  localparam int DW = $clog2(DEB_LEN);
  localparam int WW = $clog2(WIN_LEN);
  localparam int BW = $clog2(2 * BEEP_BASE);

  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_LEN - 1);
  localparam logic [WW-1:0]   WIN_LAST = WW'(WIN_LEN - 1);
  // Quarter thresholds compared against 4*total, so no division is needed.
  localparam logic [WW+2:0]   Q1       = (WW + 3)'(WIN_LEN);
  localparam logic [WW+2:0]   Q2       = (WW + 3)'(2 * WIN_LEN);
  localparam logic [WW+2:0]   Q3       = (WW + 3)'(3 * WIN_LEN);
  localparam logic [BW-1:0]   H1_LAST  = BW'(2 * BEEP_BASE - 1);
  localparam logic [BW-1:0]   H2_LAST  = BW'(BEEP_BASE - 1);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] obstacle_q;
  logic [DW-1:0]     deb_cnt [NUM_CH];

  logic [WW-1:0]     win_cnt;
  logic [WW:0]       occ [NUM_CH];
  logic [1:0]        level [NUM_CH];
  logic              window_done_q;

  logic [BW-1:0]     beep_cnt [NUM_CH];
  logic [NUM_CH-1:0] buzz_ph;
  logic [NUM_CH-1:0] en_q;

  logic              win_end;
  logic [NUM_CH-1:0] hit;
  logic [WW:0]       total [NUM_CH];
  logic [WW+2:0]     total_x4 [NUM_CH];
  logic [1:0]        next_level [NUM_CH];

  assign win_end = (win_cnt == WIN_LAST);
  assign hit     = obstacle_q & bus.ch_en;

  // Quantise the window occupancy (including the final cycle) to a level.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      total[i]    = occ[i] + (WW + 1)'(hit[i]);
      total_x4[i] = {total[i], 2'b00};
      if (total_x4[i] >= Q3)      next_level[i] = 2'd3;
      else if (total_x4[i] >= Q2) next_level[i] = 2'd2;
      else if (total_x4[i] >= Q1) next_level[i] = 2'd1;
      else                        next_level[i] = 2'd0;
    end
  end

  // Synchronise the raw sensors and debounce them into the obstacle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      obstacle_q <= '0;
      for (int i = 0; i < NUM_CH; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= bus.sensor;
      sync2 <= sync1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync2[i] == obstacle_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          obstacle_q[i] <= ~obstacle_q[i];
          deb_cnt[i]    <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Window counter, occupancy accumulation and level update at window end.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt       <= '0;
      window_done_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        occ[i]   <= '0;
        level[i] <= 2'd0;
      end
    end else begin
      win_cnt       <= win_cnt + WW'(1);
      window_done_q <= win_end;
      for (int i = 0; i < NUM_CH; i++) begin
        if (win_end) begin
          level[i] <= next_level[i];
          occ[i]   <= '0;
        end else if (!bus.ch_en[i]) begin
          occ[i] <= '0;
        end else begin
          occ[i] <= total[i];
        end
      end
    end
  end

  // Beep pattern generator; a level change restarts the pattern phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= '0;
      buzz_ph <= '0;
      for (int i = 0; i < NUM_CH; i++) beep_cnt[i] <= '0;
    end else begin
      en_q <= bus.ch_en;
      for (int i = 0; i < NUM_CH; i++) begin
        if (win_end && (next_level[i] != level[i])) begin
          beep_cnt[i] <= '0;
          buzz_ph[i]  <= (next_level[i] == 2'd3);
        end else begin
          case (level[i])
            2'd0: begin
              beep_cnt[i] <= '0;
              buzz_ph[i]  <= 1'b0;
            end
            2'd3: begin
              beep_cnt[i] <= '0;
              buzz_ph[i]  <= 1'b1;
            end
            default: begin
              if (beep_cnt[i] == ((level[i] == 2'd1) ? H1_LAST : H2_LAST)) begin
                beep_cnt[i] <= '0;
                buzz_ph[i]  <= ~buzz_ph[i];
              end else begin
                beep_cnt[i] <= beep_cnt[i] + BW'(1);
              end
            end
          endcase
        end
      end
    end
  end

  // Pack the per-channel levels onto the output bus.
  always_comb begin
    bus.buzz_level = '0;
    for (int i = 0; i < NUM_CH; i++) bus.buzz_level[2*i +: 2] = level[i];
  end

  assign bus.obstacle    = obstacle_q;
  assign bus.buzz_out    = buzz_ph & en_q;
  assign bus.window_done = window_done_q;
endmodule
